prach_hb1_int: RTL and testbench

Half-band x2 interpolator for the PRACH path, 16-channel time-multiplexed. It takes one 16-bit sample per channel per frame and emits two output phases per input sample: phase 0 is the delayed centre tap, phase 1 is the 4-tap filtered mid-point. Phase 0 is passed straight through the pipeline; phase 1 is buffered and replayed after the frame. It sits on the transmit/reconstruction side, mirroring the half-band decimator and using the same coefficients.

---
 rtl/prach_hb1_pkg.sv | 20 ++
 rtl/prach_hb1_int_if.sv | 22 ++
 rtl/delay.sv | 23 ++
 rtl/prach_hb1_ph1_buf.sv | 24 ++
 rtl/prach_hb1_int.sv | 148 ++++++++++++++
 tb/tb_prach_hb1_int.sv | 232 +++++++++++++++++++++++
 6 files changed

// File: rtl/prach_hb1_pkg.sv
// rtl/prach_hb1_pkg.sv - shared constants, types and helpers for the PRACH half-band x2 interpolator
package prach_hb1_pkg;
  localparam int NumChannel = 16;
  localparam int ChnBits    = 4;
  localparam int TapLen     = 3 * NumChannel + 1;

  // fi(1,18,17): index 0 pairs with the outer taps, index 1 with the inner taps
  localparam logic signed [17:0] Coef [2] = '{-18'sd4134, 18'sd36901};
  localparam logic signed [35:0] RoundConst = 36'sd32768;
  localparam logic signed [15:0] SatMax = 16'sh7fff;
  localparam logic signed [15:0] SatMin = 16'sh8000;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'(SatMax)) return SatMax;
    if (v < 20'(SatMin)) return SatMin;
    return v[15:0];
  endfunction
endpackage

// File: rtl/prach_hb1_int_if.sv
// rtl/prach_hb1_int_if.sv - TDM sample-in / interpolated sample-out bundle
interface prach_hb1_int_if;
  logic signed [15:0] din_dq;
  logic               din_dv;
  logic [7:0]         din_chn;
  logic               sync_in;
  logic signed [15:0] dout_dq;
  logic               dout_dv;
  logic [7:0]         dout_chn;
  logic               dout_ph;
  logic               sync_out;
  logic               err;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dq, dout_dv, dout_chn, dout_ph, sync_out, err
  );
  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dq, dout_dv, dout_chn, dout_ph, sync_out, err
  );
endinterface

// File: rtl/delay.sv
// rtl/delay.sv - fixed-latency register pipe used to align control with the datapath
module delay #(
  parameter int Width = 1,
  parameter int Depth = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);
  logic [Width-1:0] pipe [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < Depth; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[Depth-1];
endmodule

// File: rtl/prach_hb1_ph1_buf.sv
// rtl/prach_hb1_ph1_buf.sv - per-channel phase-1 holding buffer, written by the pipeline and read by the drain
module prach_hb1_ph1_buf
  import prach_hb1_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ChnBits-1:0]  wr_addr,
  input  logic signed [15:0]  wr_data,
  input  logic [ChnBits-1:0]  rd_addr,
  output logic signed [15:0]  rd_data
);
  logic signed [15:0] mem [NumChannel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumChannel; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/prach_hb1_int.sv
// rtl/prach_hb1_int.sv - 16-channel TDM half-band x2 interpolator: centre tap passes through, filtered phase is replayed after the frame
module prach_hb1_int
  import prach_hb1_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  prach_hb1_int_if.slave io
);
  state_t             state, state_nxt;
  logic [ChnBits-1:0] cnt;
  logic               start, chn_ok, accept, viol, drain_rd;

  assign start  = io.din_dv && (io.din_chn == '0) && io.sync_in;
  assign chn_ok = (io.din_chn == 8'(cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (!io.din_dv || !chn_ok) state_nxt = IDLE;
               else if (cnt == ChnBits'(NumChannel - 1)) state_nxt = DRAIN;
      DRAIN:   if (cnt == ChnBits'(NumChannel - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    viol     = 1'b0;
    drain_rd = 1'b0;
    case (state)
      IDLE:  begin accept = start; viol = io.din_dv && !start; end
      LOAD:  begin accept = io.din_dv && chn_ok; viol = !(io.din_dv && chn_ok); end
      DRAIN: begin drain_rd = 1'b1; viol = io.din_dv; end
      default: ;
    endcase
  end

  // LOAD expects channel 1 next since the channel-0 sample is taken in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state_nxt == IDLE)  cnt <= '0;
    else if (state == IDLE)      cnt <= ChnBits'(1);
    else                         cnt <= cnt + ChnBits'(1);
  end

  logic signed [15:0] tap [TapLen];
  logic signed [16:0] pa_out, pa_in;
  logic signed [34:0] pr_out, pr_in;
  logic signed [35:0] acc_sum;
  logic signed [19:0] rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TapLen; i++) tap[i] <= '0;
    end else if (accept) begin
      tap[0] <= io.din_dq;
      for (int i = 1; i < TapLen; i++) tap[i] <= tap[i-1];
    end
  end

  assign acc_sum = 36'(pr_out) + 36'(pr_in) + RoundConst;

  // Shift by 16 rather than 17 folds in the x2 interpolation gain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_out <= '0;
      pa_in  <= '0;
      pr_out <= '0;
      pr_in  <= '0;
      rnd    <= '0;
    end else begin
      pa_out <= 17'(tap[0]) + 17'(tap[3*NumChannel]);
      pa_in  <= 17'(tap[NumChannel]) + 17'(tap[2*NumChannel]);
      pr_out <= 35'(pa_out) * 35'(Coef[0]);
      pr_in  <= 35'(pa_in) * 35'(Coef[1]);
      rnd    <= acc_sum[35:16];
    end
  end

  logic [9:0]         ctl_bus;
  logic               p0_v, p0_sync;
  logic [7:0]         p0_chn;
  logic signed [15:0] p0_dq;
  logic [20:0]        dr_bus;
  logic               dr_v;
  logic [ChnBits-1:0] dr_chn;
  logic signed [15:0] dr_dq, rd_data;

  delay #(.Width(10), .Depth(4)) u_ctl_dly (
    .clk(clk), .rst_n(rst_n),
    .din({accept, io.sync_in, io.din_chn}), .dout(ctl_bus)
  );
  delay #(.Width(16), .Depth(3)) u_p0_dly (
    .clk(clk), .rst_n(rst_n),
    .din(tap[2*NumChannel]), .dout(p0_dq)
  );
  delay #(.Width(21), .Depth(4)) u_drain_dly (
    .clk(clk), .rst_n(rst_n),
    .din({drain_rd, cnt, rd_data}), .dout(dr_bus)
  );

  assign {p0_v, p0_sync, p0_chn} = ctl_bus;
  assign {dr_v, dr_chn, dr_dq}   = dr_bus;

  prach_hb1_ph1_buf u_ph1_buf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(p0_v), .wr_addr(p0_chn[ChnBits-1:0]), .wr_data(sat16(rnd)),
    .rd_addr(cnt), .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.dout_dq  <= '0;
      io.dout_dv  <= 1'b0;
      io.dout_chn <= '0;
      io.dout_ph  <= 1'b0;
      io.sync_out <= 1'b0;
      io.err      <= 1'b0;
    end else begin
      io.err <= viol;
      if (p0_v) begin
        io.dout_dq  <= p0_dq;
        io.dout_dv  <= 1'b1;
        io.dout_chn <= p0_chn;
        io.dout_ph  <= 1'b0;
        io.sync_out <= p0_sync;
      end else if (dr_v) begin
        io.dout_dq  <= dr_dq;
        io.dout_dv  <= 1'b1;
        io.dout_chn <= 8'(dr_chn);
        io.dout_ph  <= 1'b1;
        io.sync_out <= 1'b0;
      end else begin
        io.dout_dq  <= '0;
        io.dout_dv  <= 1'b0;
        io.dout_chn <= '0;
        io.dout_ph  <= 1'b0;
        io.sync_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prach_hb1_int.sv
// tb/tb_prach_hb1_int.sv - scoreboard and vector-table bench for the PRACH half-band interpolator
module tb_prach_hb1_int;
  typedef struct { int cyc; int dq; int chn; int ph; int sync; } exp_t;
  typedef struct { int ch; int x[4]; int y1; int y0; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prach_hb1_int_if io();
  prach_hb1_int dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   eq[$];
  int   hist [16][4];
  int   seen [2][16];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // a = newest sample of the channel, d = oldest
  function automatic int ref_y1(input int a, input int b, input int c, input int d);
    longint acc;
    acc = longint'(-4134) * (a + d) + longint'(36901) * (b + c);
    acc = (acc + 32768) >>> 16;
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_idle();
    io.din_dv  = 1'b0;
    io.din_chn = '0;
    io.din_dq  = '0;
    io.sync_in = 1'b0;
  endtask

  task automatic clear_model();
    foreach (hist[c, j]) hist[c][j] = 0;
    sb.delete();
    eq.delete();
  endtask

  task automatic rand_frame(output int smp[16]);
    logic signed [15:0] r;
    for (int k = 0; k < 16; k++) begin
      r = 16'($urandom);
      smp[k] = r;
    end
  endtask

  task automatic send_frame(input int smp[16], input int n_samp, output int t0);
    int   y1[16];
    exp_t e;
    t0 = cyc;
    for (int k = 0; k < n_samp; k++) begin
      tick();
      if (k == 0) t0 = cyc;
      io.din_dv  = 1'b1;
      io.din_chn = 8'(k);
      io.sync_in = (k == 0);
      io.din_dq  = 16'(smp[k]);
      for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = smp[k];
      y1[k] = ref_y1(hist[k][0], hist[k][1], hist[k][2], hist[k][3]);
      e = '{t0 + 5 + k, hist[k][2], k, 0, int'(k == 0)};
      sb.push_back(e);
    end
    tick();
    drive_idle();
    if (n_samp == 16) begin
      for (int k = 0; k < 16; k++) begin
        e = '{t0 + 21 + k, y1[k], k, 1, 0};
        sb.push_back(e);
      end
    end else begin
      eq.push_back(t0 + n_samp + 1);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dq"}, io.dout_dq, 0);
    chk({tag, "_dv"}, io.dout_dv, 0);
    chk({tag, "_chn"}, io.dout_chn, 0);
    chk({tag, "_ph"}, io.dout_ph, 0);
    chk({tag, "_sync"}, io.sync_out, 0);
    chk({tag, "_err"}, io.err, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   exp_dv, exp_err;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_out: chn %0d ph %0d due at cycle %0d never seen, now cycle %0d",
               sb[0].chn, sb[0].ph, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    exp_dv = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("dout_dv", io.dout_dv, int'(exp_dv));
    if (exp_dv) begin
      e = sb.pop_front();
      if (io.dout_dv) begin
        chk($sformatf("dq_c%0d_p%0d", e.chn, e.ph), io.dout_dq, e.dq);
        chk("dout_chn", io.dout_chn, e.chn);
        chk("dout_ph", io.dout_ph, e.ph);
        chk("sync_out", io.sync_out, e.sync);
      end
    end else begin
      chk("sync_out_idle", io.sync_out, 0);
    end
    while (eq.size() > 0 && eq[0] < cyc) void'(eq.pop_front());
    exp_err = (eq.size() > 0) && (eq[0] == cyc);
    if (exp_err) void'(eq.pop_front());
    chk("err", io.err, int'(exp_err));
    if (io.dout_dv) seen[io.dout_ph][io.dout_chn[3:0]] = io.dout_dq;
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : main
    int   smp[16];
    int   z[16];
    int   t0;
    vec_t tbl[9];

    tbl = '{
      '{3,  '{16384, 0, 0, 0},              -1033,  0},
      '{3,  '{0, 16384, 0, 0},               9225,  16384},
      '{3,  '{0, 0, 16384, 0},               9225,  0},
      '{3,  '{0, 0, 0, 16384},              -1033,  0},
      '{0,  '{32767, 32767, 32767, 32767},   32766,  32767},
      '{0,  '{-32768, 32767, 32767, -32768}, 32767,  32767},
      '{15, '{32767, -32768, -32768, 32767}, -32768, -32768},
      '{7,  '{-32768, -32768, -32768, -32768}, -32767, -32768},
      '{9,  '{100, 200, 300, 400},           250,    200}
    };

    drive_idle();
    clear_model();
    rst_n = 1'b0;
    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // full frame, then an illegal sample mid-drain and one in IDLE
    rand_frame(smp);
    send_frame(smp, 16, t0);
    while (cyc < t0 + 25) tick();
    io.din_dv = 1'b1; io.din_chn = 8'd5; io.din_dq = 16'sd12345;
    eq.push_back(cyc + 1);
    tick();
    drive_idle();
    while (cyc < t0 + 40) tick();
    io.din_dv = 1'b1; io.din_chn = 8'd2; io.din_dq = 16'sd777;
    eq.push_back(cyc + 1);
    tick();
    drive_idle();
    idle(16);

    // minimum inter-frame gap
    rand_frame(smp);
    send_frame(smp, 16, t0);
    idle(15);
    rand_frame(smp);
    send_frame(smp, 16, t0);
    idle(16);

    // dv dropped after 8 samples: phase 0 only, no drain
    rand_frame(smp);
    send_frame(smp, 8, t0);
    idle(30);
    rst_n = 1'b0;
    clear_model();
    idle(2);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      rand_frame(smp);
      send_frame(smp, 16, t0);
      while (cyc < t0 + 28) tick();
      rst_n = 1'b0;
      clear_model();
      #1;
      check_zero($sformatf("rst_drain%0d", i));
      idle(2);
      rst_n = 1'b1;
      tick();
      for (int f = 0; f < 4; f++) begin
        z = '{default: 0};
        z[tbl[i].ch] = tbl[i].x[f];
        if (f == 3) foreach (seen[p, c]) seen[p][c] = -99999;
        send_frame(z, 16, t0);
        idle(24);
      end
      chk($sformatf("vec%0d_ph1", i), seen[1][tbl[i].ch], tbl[i].y1);
      chk($sformatf("vec%0d_ph0", i), seen[0][tbl[i].ch], tbl[i].y0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
